// File: rtl/sequence_stimulus_generator.sv
// -----------------------------------------------------------------------------
// sequence_stimulus_generator
//   Transmit side of the serial-w link feeding the run-of-identical-bits
//   detector. A burst latches a pattern word and shifts it out LSB-first, one
//   bit per Advance step. In parallel, a golden run tracker produces the z the
//   detector is expected to raise (ExpectZ), plus a per-burst hit count.
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   synchronous, active-high reset (priority over everything)
//   Load     in   start a burst; only honoured in IDLE
//   Pattern  in   bits to send, bit 0 first
//   Length   in   number of bits to send (clamped to PAT_WIDTH, 0 = ignore)
//   Advance  in   step enable while shifting
//   w        out  serial bit; holds its last value between steps
//   w_valid  out  1-cycle pulse marking a newly emitted w
//   Busy     out  high while shifting and during the Done cycle
//   Done     out  1-cycle pulse the cycle after the last w_valid
//   ExpectZ  out  golden detector output for the current w
//   DetCount out  emitted bits with ExpectZ=1 in this burst
// -----------------------------------------------------------------------------
module sequence_stimulus_generator #(
   parameter int PAT_WIDTH = 16,
   parameter int RUN_LEN   = 4,
   localparam int LW = $clog2(PAT_WIDTH) + 1,
   localparam int CW = $clog2(PAT_WIDTH + 1)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Load,
   input  logic [PAT_WIDTH-1:0] Pattern,
   input  logic [LW-1:0]        Length,
   input  logic                 Advance,
   output logic                 w,
   output logic                 w_valid,
   output logic                 Busy,
   output logic                 Done,
   output logic                 ExpectZ,
   output logic [CW-1:0]        DetCount
);

   localparam int RW = $clog2(RUN_LEN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [PAT_WIDTH-1:0] sreg_q, sreg_d;
   logic [LW-1:0]        rem_q, rem_d;
   logic [RW-1:0]        run_q, run_d;
   logic                 w_q, w_d;
   logic                 wv_q, wv_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 expz_q, expz_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      rem_d   = rem_q;
      run_d   = run_q;
      w_d     = w_q;
      wv_d    = 1'b0;
      done_d  = 1'b0;
      expz_d  = expz_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (Load && (Length != '0)) begin
               sreg_d  = Pattern;
               rem_d   = (Length > LW'(PAT_WIDTH)) ? LW'(PAT_WIDTH) : Length;
               run_d   = '0;  // run==0 marks "no bit emitted yet in this burst"
               expz_d  = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rem_q == '0) begin
               // Last bit went out on the previous step; Done follows it.
               state_d = DONE;
               done_d  = 1'b1;
            end else if (Advance) begin
               w_d    = sreg_q[0];
               wv_d   = 1'b1;
               sreg_d = sreg_q >> 1;
               rem_d  = rem_q - 1'b1;
               if ((run_q == '0) || (sreg_q[0] != w_q))
                  run_d = RW'(1);
               else if (run_q >= RW'(RUN_LEN))
                  run_d = RW'(RUN_LEN);  // saturate so overlapping runs keep z high
               else
                  run_d = run_q + 1'b1;
               expz_d = (run_d == RW'(RUN_LEN));
               cnt_d  = cnt_q + CW'(expz_d);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         rem_q   <= '0;
         run_q   <= '0;
         w_q     <= 1'b0;
         wv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         expz_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         rem_q   <= rem_d;
         run_q   <= run_d;
         w_q     <= w_d;
         wv_q    <= wv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         expz_q  <= expz_d;
         cnt_q   <= cnt_d;
      end
   end

   assign w        = w_q;
   assign w_valid  = wv_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign ExpectZ  = expz_q;
   assign DetCount = cnt_q;

endmodule

// File: tb/tb_sequence_stimulus_generator.sv
module tb_sequence_stimulus_generator;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Load;
   logic [15:0] Pattern;
   logic [4:0]  Length;
   logic        Advance;
   logic        w, w_valid, Busy, Done, ExpectZ;
   logic [4:0]  DetCount;

   int checks = 0;
   int errors = 0;

   // Last observed-and-expected values that must hold between steps.
   logic       last_w;
   logic       last_z;
   logic [4:0] last_cnt;
   int         pulses;

   always #5 Clock = ~Clock;

   sequence_stimulus_generator #(.PAT_WIDTH(16), .RUN_LEN(4)) dut (
      .Clock(Clock), .Reset(Reset), .Load(Load), .Pattern(Pattern),
      .Length(Length), .Advance(Advance), .w(w), .w_valid(w_valid),
      .Busy(Busy), .Done(Done), .ExpectZ(ExpectZ), .DetCount(DetCount)
   );

   // Packed view {Busy,Done,w_valid,w,ExpectZ,DetCount} for compact comparisons.
   function automatic logic [9:0] obs();
      return {Busy, Done, w_valid, w, ExpectZ, DetCount};
   endfunction

   task automatic check_vec(input string name, input logic [9:0] exp);
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL %s: got {B,D,V,w,Z,cnt}=%b expected %b at %0t", name, obs(), exp, $time);
      end
   endtask

   // Drive a burst. mode: 0 Advance always, 1 every 3rd cycle, 2 random.
   // stop_after >= 0 returns once that many bits have gone out (burst left running).
   task automatic run_burst(input logic [15:0] pat, input int len, input int mode,
                            input bit midload, input int stop_after);
      int  n, sent, cyc, k, c;
      bit  b[16];
      bit  ez[16];
      int  ec[16];
      bit  adv;
      n = (len > 16) ? 16 : len;
      c = 0;
      // Reference: ExpectZ when the identical-bit run ending at bit i is >= RUN_LEN.
      for (int i = 0; i < n; i++) begin
         b[i] = pat[i];
         k = 0;
         while (k <= i && b[i-k] == b[i]) k++;
         ez[i] = (k >= 4);
         c += int'(ez[i]);
         ec[i] = c;
      end
      @(negedge Clock);
      Load = 1'b1; Pattern = pat; Length = 5'(len); Advance = 1'b0;
      @(negedge Clock);
      Load = 1'b0; Pattern = 16'($urandom); Length = 5'($urandom);
      last_z = 1'b0; last_cnt = '0;
      check_vec("load_accept", {1'b1, 1'b0, 1'b0, last_w, 1'b0, 5'd0});
      sent = 0; cyc = 0; pulses = 0;
      while (sent < n && cyc < 200) begin
         if (stop_after >= 0 && sent == stop_after) return;
         case (mode)
            0:       adv = 1'b1;
            1:       adv = (cyc % 3 == 2);
            default: adv = 1'($urandom_range(0, 1));
         endcase
         Advance = adv;
         Load    = midload && (cyc == 4);
         Pattern = 16'($urandom);
         Length  = 5'($urandom_range(1, 16));
         @(negedge Clock);
         cyc++;
         if (adv) begin
            last_w = b[sent]; last_z = ez[sent]; last_cnt = 5'(ec[sent]);
            sent++;
            pulses++;
            check_vec("shift_step", {1'b1, 1'b0, 1'b1, last_w, last_z, last_cnt});
         end else begin
            check_vec("shift_hold", {1'b1, 1'b0, 1'b0, last_w, last_z, last_cnt});
         end
      end
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL burst_timeout: sent %0d of %0d bits", sent, n);
      end
      Advance = 1'($urandom_range(0, 1));
      Load    = midload;
      @(negedge Clock);
      Load = 1'b0; Advance = 1'b0;
      check_vec("done_pulse", {1'b1, 1'b1, 1'b0, last_w, last_z, last_cnt});
      @(negedge Clock);
      check_vec("idle_hold", {1'b0, 1'b0, 1'b0, last_w, last_z, last_cnt});
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      last_w = 1'b0; last_z = 1'b0; last_cnt = '0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Load = 1'b0; Pattern = '0; Length = '0; Advance = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      last_w = 1'b0; last_z = 1'b0; last_cnt = '0;
      check_vec("reset_state", 10'd0);
      @(negedge Clock);
      do_reset();
      check_vec("reset_idle", 10'd0);
   endtask

   task automatic test_f0_burst();
      run_burst(16'h00F0, 12, 0, 1'b0, -1);
      checks++;
      if (DetCount !== 5'd3) begin
         errors++;
         $display("FAIL f0_detcount: got %0d expected 3", DetCount);
      end
   endtask

   task automatic test_alternating();
      run_burst(16'hAAAA, 16, 0, 1'b0, -1);
      checks++;
      if (DetCount !== 5'd0 || pulses != 16) begin
         errors++;
         $display("FAIL alt_burst: cnt %0d pulses %0d expected 0 and 16", DetCount, pulses);
      end
   endtask

   task automatic test_clamp();
      run_burst(16'hFFFF, 20, 0, 1'b0, -1);
      checks++;
      if (DetCount !== 5'd13 || pulses != 16) begin
         errors++;
         $display("FAIL clamp_burst: cnt %0d pulses %0d expected 13 and 16", DetCount, pulses);
      end
   endtask

   task automatic test_sparse_advance_midload();
      run_burst(16'h3C0F, 14, 1, 1'b1, -1);
   endtask

   task automatic test_reset_midburst();
      run_burst(16'h0FF0, 10, 0, 1'b0, 5);
      do_reset();
      check_vec("midburst_reset", 10'd0);
      Load = 1'b1; Length = 5'd0; Pattern = 16'hFFFF;
      @(negedge Clock);
      Load = 1'b0;
      check_vec("len0_ignored", 10'd0);
      @(negedge Clock);
      check_vec("len0_no_done", 10'd0);
      run_burst(16'h000F, 4, 0, 1'b0, -1);
      checks++;
      if (DetCount !== 5'd1) begin
         errors++;
         $display("FAIL post_reset_burst: cnt %0d expected 1", DetCount);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++)
         run_burst(16'($urandom), $urandom_range(1, 20), 2, 1'($urandom_range(0, 1)), -1);
   endtask

   initial begin
      test_reset();
      test_f0_burst();
      test_alternating();
      test_clamp();
      test_sparse_advance_midload();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
